clint_arbiter: RTL



---
 rtl/clint_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/clint_arbiter.sv
// Round-robin arbiter sharing the CLINT register port between imem and dmem requesters.
// Optional response timeout enabled by defining CLINT_ARB_TIMEOUT_EN.
module clint_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_valid,
    input  logic [31:0] imem_addr,
    input  logic [31:0] imem_wdata,
    input  logic [3:0]  imem_wstrb,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        clint_valid,
    output logic        clint_instr,
    output logic [31:0] clint_addr,
    output logic [31:0] clint_wdata,
    output logic [3:0]  clint_wstrb,
    input  logic [31:0] clint_rdata,
    input  logic        clint_ready,
    output logic        arb_error
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t      state, state_nxt;
    logic        imem_pend, dmem_pend;
    logic [31:0] imem_slot_addr, imem_slot_wdata, dmem_slot_addr, dmem_slot_wdata;
    logic [3:0]  imem_slot_wstrb, dmem_slot_wstrb;
    logic        last_dmem, owner_dmem;
    logic        grant, grant_dmem, complete, expire;
    logic        imem_capture, dmem_capture;

    logic        clint_valid_nxt, clint_instr_nxt;
    logic [31:0] clint_addr_nxt, clint_wdata_nxt;
    logic [3:0]  clint_wstrb_nxt;
    logic        imem_ready_nxt, dmem_ready_nxt, arb_error_nxt;
    logic [31:0] imem_rdata_nxt, dmem_rdata_nxt;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("clint_arbiter: TIMEOUT must be in 2..255");
    end

    always_comb begin
        grant        = (state == IDLE) && (imem_pend || dmem_pend);
        grant_dmem   = dmem_pend && (!imem_pend || !last_dmem);
        complete     = (state == WAIT) && clint_ready;
        // A port whose request is outstanding cannot queue a second one.
        imem_capture = imem_valid && !imem_pend && !((state == WAIT) && !owner_dmem);
        dmem_capture = dmem_valid && !dmem_pend && !((state == WAIT) && owner_dmem);
    end

`ifdef CLINT_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] tmo_cnt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (grant) begin
            tmo_cnt <= '0;
        end else if ((state == WAIT) && !clint_ready) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    assign expire = (state == WAIT) && !clint_ready && (tmo_cnt == TMO_LAST);
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = WAIT;
            WAIT:    if (complete || expire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        clint_valid_nxt = grant;
        clint_instr_nxt = clint_instr;
        clint_addr_nxt  = clint_addr;
        clint_wdata_nxt = clint_wdata;
        clint_wstrb_nxt = clint_wstrb;
        if (grant) begin
            clint_instr_nxt = !grant_dmem;
            clint_addr_nxt  = grant_dmem ? dmem_slot_addr  : imem_slot_addr;
            clint_wdata_nxt = grant_dmem ? dmem_slot_wdata : imem_slot_wdata;
            clint_wstrb_nxt = grant_dmem ? dmem_slot_wstrb : imem_slot_wstrb;
        end
        imem_ready_nxt = (complete || expire) && !owner_dmem;
        dmem_ready_nxt = (complete || expire) && owner_dmem;
        imem_rdata_nxt = (complete && !owner_dmem) ? clint_rdata : 32'd0;
        dmem_rdata_nxt = (complete && owner_dmem) ? clint_rdata : 32'd0;
        arb_error_nxt  = expire;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            clint_valid <= 1'b0;
            clint_instr <= 1'b0;
            clint_addr  <= '0;
            clint_wdata <= '0;
            clint_wstrb <= '0;
            imem_ready  <= 1'b0;
            dmem_ready  <= 1'b0;
            imem_rdata  <= '0;
            dmem_rdata  <= '0;
            arb_error   <= 1'b0;
        end else begin
            clint_valid <= clint_valid_nxt;
            clint_instr <= clint_instr_nxt;
            clint_addr  <= clint_addr_nxt;
            clint_wdata <= clint_wdata_nxt;
            clint_wstrb <= clint_wstrb_nxt;
            imem_ready  <= imem_ready_nxt;
            dmem_ready  <= dmem_ready_nxt;
            imem_rdata  <= imem_rdata_nxt;
            dmem_rdata  <= dmem_rdata_nxt;
            arb_error   <= arb_error_nxt;
        end
    end

    // last_dmem resets to 1 so imem wins the first tie.
    always_ff @(posedge clock) begin
        if (!reset) begin
            imem_pend       <= 1'b0;
            dmem_pend       <= 1'b0;
            last_dmem       <= 1'b1;
            owner_dmem      <= 1'b0;
            imem_slot_addr  <= '0;
            imem_slot_wdata <= '0;
            imem_slot_wstrb <= '0;
            dmem_slot_addr  <= '0;
            dmem_slot_wdata <= '0;
            dmem_slot_wstrb <= '0;
        end else begin
            if (grant) begin
                last_dmem  <= grant_dmem;
                owner_dmem <= grant_dmem;
                if (grant_dmem) dmem_pend <= 1'b0;
                else            imem_pend <= 1'b0;
            end
            if (imem_capture) begin
                imem_pend       <= 1'b1;
                imem_slot_addr  <= imem_addr;
                imem_slot_wdata <= imem_wdata;
                imem_slot_wstrb <= imem_wstrb;
            end
            if (dmem_capture) begin
                dmem_pend       <= 1'b1;
                dmem_slot_addr  <= dmem_addr;
                dmem_slot_wdata <= dmem_wdata;
                dmem_slot_wstrb <= dmem_wstrb;
            end
        end
    end

endmodule
